// File: rtl/sram_ctrl_pkg.sv
// Shared types and default widths for the SRAM access controller.
package sram_ctrl_pkg;

  localparam int ADDR_W_DEF       = 16;
  localparam int DATA_W_DEF       = 8;
  localparam int WRITE_CYCLES_DEF = 1;
  localparam int READ_CYCLES_DEF  = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DUMP  = 3'd3,
    GAP   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_RD   = 2'd0,
    OP_WR   = 2'd1,
    OP_DUMP = 2'd2
  } op_t;

endpackage

// File: rtl/sram_access_ctrl.sv
// Single-beat SRAM initiator: one access in flight, fixed strobe hold times,
// and a mandatory idle GAP cycle so every strobe drops between accesses.
module sram_access_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int WRITE_CYCLES = WRITE_CYCLES_DEF,
  parameter int READ_CYCLES  = READ_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              dump_req,
  input  logic              dump_num,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              sram_read,
  output logic              sram_write,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              sram_dump,
  output logic              sram_dump_num
);

  localparam int MAX_CYC = (WRITE_CYCLES > READ_CYCLES) ? WRITE_CYCLES : READ_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(WRITE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(READ_CYCLES - 1);

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  op_t              op_r;
  logic             accept_s;
  logic             take_dump_s;
  logic             rd_done_s;

  // Next-state, counter and request/dump acceptance decode.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    accept_s    = 1'b0;
    take_dump_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          if (req_write) begin
            state_s = WRITE;
            cnt_s   = WR_LOAD;
          end else begin
            state_s = READ;
            cnt_s   = RD_LOAD;
          end
        end else if (dump_req) begin
          take_dump_s = 1'b1;
          state_s     = DUMP;
        end else begin
          state_s = IDLE;
        end
      end
      WRITE, READ: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = GAP;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      DUMP:    state_s = GAP;
      GAP:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Read completes on the edge that leaves READ; that edge captures sram_rdata.
  assign rd_done_s = (state_r == READ) && (op_r == OP_RD) && (cnt_r == CNT_ZERO);

  // State, hold counter and latched operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      op_r    <= OP_RD;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (accept_s) begin
        op_r <= req_write ? OP_WR : OP_RD;
      end else if (take_dump_s) begin
        op_r <= OP_DUMP;
      end
    end
  end

  // Registered outputs, driven from the next state so strobes align with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready     <= 1'b1;
      busy          <= 1'b0;
      sram_read     <= 1'b0;
      sram_write    <= 1'b0;
      sram_dump     <= 1'b0;
      sram_addr     <= {ADDR_W{1'b0}};
      sram_wdata    <= {DATA_W{1'b0}};
      sram_dump_num <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= {DATA_W{1'b0}};
    end else begin
      req_ready  <= (state_s == IDLE);
      busy       <= (state_s != IDLE);
      sram_read  <= (state_s == READ);
      sram_write <= (state_s == WRITE);
      sram_dump  <= (state_s == DUMP);
      rsp_valid  <= rd_done_s;
      // Address/data registers double as the request latch and hold while idle.
      if (accept_s) begin
        sram_addr <= req_addr;
        if (req_write) begin
          sram_wdata <= req_wdata;
        end
      end
      if (take_dump_s) begin
        sram_dump_num <= dump_num;
      end
      if (rd_done_s) begin
        rsp_rdata <= sram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Randomized self-checking bench for sram_access_ctrl with a behavioural SRAM
// and a transaction-level memory model; a second build checks longer hold times.
module tb_sram_access_ctrl;

  localparam int WC   = 1;
  localparam int RC   = 2;
  localparam int WC_B = 3;
  localparam int RC_B = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_write, dump_req, dump_num;
  logic [15:0] req_addr, sram_addr;
  logic [7:0]  req_wdata, sram_wdata, sram_rdata, rsp_rdata;
  logic        rsp_valid, busy, sram_read, sram_write, sram_dump, sram_dump_num;

  logic        b_req_valid, b_req_ready, b_req_write, b_dump_req, b_dump_num;
  logic [15:0] b_req_addr, b_sram_addr;
  logic [7:0]  b_req_wdata, b_sram_wdata, b_sram_rdata, b_rsp_rdata;
  logic        b_rsp_valid, b_busy, b_sram_read, b_sram_write, b_sram_dump, b_sram_dump_num;

  sram_access_ctrl #(.ADDR_W(16), .DATA_W(8), .WRITE_CYCLES(WC), .READ_CYCLES(RC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .dump_req(dump_req), .dump_num(dump_num),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy), .sram_read(sram_read),
    .sram_write(sram_write), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_dump(sram_dump), .sram_dump_num(sram_dump_num));

  sram_access_ctrl #(.ADDR_W(16), .DATA_W(8), .WRITE_CYCLES(WC_B), .READ_CYCLES(RC_B)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .dump_req(b_dump_req), .dump_num(b_dump_num),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .busy(b_busy), .sram_read(b_sram_read),
    .sram_write(b_sram_write), .sram_addr(b_sram_addr), .sram_wdata(b_sram_wdata),
    .sram_rdata(b_sram_rdata), .sram_dump(b_sram_dump), .sram_dump_num(b_sram_dump_num));

  // Behavioural SRAMs: synchronous write, combinational read while strobed.
  logic [7:0] mem_a [0:65535];
  logic [7:0] mem_b [0:65535];
  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem_a[i] = 8'h00;
      mem_b[i] = 8'h00;
    end
  end
  always @(posedge clk) begin
    if (sram_write)   mem_a[sram_addr]   <= sram_wdata;
    if (b_sram_write) mem_b[b_sram_addr] <= b_sram_wdata;
  end
  assign sram_rdata   = sram_read   ? mem_a[sram_addr]   : 8'h00;
  assign b_sram_rdata = b_sram_read ? mem_b[b_sram_addr] : 8'h00;

  int total = 0;
  int bad   = 0;
  int overlap = 0;

  // Read and write strobes must never be seen together on either build.
  always @(negedge clk) begin
    if (sram_read && sram_write)     overlap++;
    if (b_sram_read && b_sram_write) overlap++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level memory model: unwritten locations read as zero.
  logic [7:0] ref_mem [int];
  function automatic logic [7:0] ref_read(input logic [15:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return 8'h00;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One access on the main build; hold keeps req_valid high with junk payload while busy.
  task automatic do_access(input logic wr, input logic [15:0] addr, input logic [7:0] data,
                           input bit hold);
    int n;
    logic [7:0] exp_rd;
    int waited = 0;
    while (req_ready !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    check_eq("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = data;
    exp_rd = ref_read(addr);
    if (wr) ref_mem[int'(addr)] = data;
    step();
    if (hold) begin
      req_write = ~wr; req_addr = ~addr; req_wdata = ~data;
    end else begin
      req_valid = 1'b0;
    end
    n = wr ? WC : RC;
    for (int k = 0; k < n; k++) begin
      check_eq(wr ? "wr_strobe" : "rd_strobe", {31'd0, wr ? sram_write : sram_read}, 32'd1);
      check_eq("other_strobe_low", {31'd0, wr ? sram_read : sram_write}, 32'd0);
      check_eq("dump_low_in_access", {31'd0, sram_dump}, 32'd0);
      check_eq("strobe_addr", {16'd0, sram_addr}, {16'd0, addr});
      if (wr) check_eq("strobe_wdata", {24'd0, sram_wdata}, {24'd0, data});
      check_eq("ready_low_busy", {30'd0, req_ready, busy}, 32'd1);
      check_eq("no_rsp_in_strobe", {31'd0, rsp_valid}, 32'd0);
      step();
    end
    check_eq("gap_strobes_low", {29'd0, sram_read, sram_write, sram_dump}, 32'd0);
    check_eq("gap_ready_low", {31'd0, req_ready}, 32'd0);
    check_eq("gap_rsp_valid", {31'd0, rsp_valid}, {31'd0, ~wr});
    if (!wr) check_eq("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, exp_rd});
    step();
    check_eq("idle_ready", {30'd0, req_ready, busy}, 32'd2);
    check_eq("idle_rsp_low", {31'd0, rsp_valid}, 32'd0);
    if (!wr) check_eq("rsp_rdata_held", {24'd0, rsp_rdata}, {24'd0, exp_rd});
  endtask

  task automatic do_dump(input logic num);
    check_eq("ready_before_dump", {31'd0, req_ready}, 32'd1);
    dump_req = 1'b1; dump_num = num;
    step();
    dump_req = 1'b0;
    check_eq("dump_strobe", {31'd0, sram_dump}, 32'd1);
    check_eq("dump_num", {31'd0, sram_dump_num}, {31'd0, num});
    check_eq("dump_rw_low", {30'd0, sram_read, sram_write}, 32'd0);
    check_eq("dump_ready_low", {31'd0, req_ready}, 32'd0);
    step();
    check_eq("dump_gap", {30'd0, sram_dump, req_ready}, 32'd0);
    step();
    check_eq("dump_idle_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [15:0] pool [8];
    int width, pulses, pulse_at;
    logic [7:0] got_rd;

    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 16'd0; req_wdata = 8'd0;
    dump_req = 1'b0; dump_num = 1'b0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 16'd0; b_req_wdata = 8'd0;
    b_dump_req = 1'b0; b_dump_num = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready_busy", {30'd0, req_ready, busy}, 32'd2);
    check_eq("rst_strobes", {28'd0, sram_read, sram_write, sram_dump, sram_dump_num}, 32'd0);
    check_eq("rst_addr_data", {sram_addr, sram_wdata, rsp_rdata}, 32'd0);
    check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Directed writes and reads.
    do_access(1'b1, 16'd0,   8'd89,  1'b0);
    do_access(1'b1, 16'd59,  8'd210, 1'b0);
    do_access(1'b1, 16'd195, 8'd66,  1'b0);
    do_access(1'b0, 16'd0,   8'd0,   1'b0);
    do_access(1'b0, 16'd59,  8'd0,   1'b0);
    do_access(1'b0, 16'd195, 8'd0,   1'b0);

    // Back-to-back with req_valid held high throughout.
    do_access(1'b1, 16'd300, 8'h3C, 1'b1);
    do_access(1'b0, 16'd300, 8'h00, 1'b1);
    do_access(1'b1, 16'd301, 8'hC3, 1'b1);
    do_access(1'b0, 16'd59,  8'h00, 1'b1);
    req_valid = 1'b0;

    // Request and dump together: request first, then the dump.
    dump_req = 1'b1; dump_num = 1'b0;
    do_access(1'b0, 16'd59, 8'd0, 1'b0);
    do_dump(1'b0);

    // Reset in the middle of a read.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'd195;
    step();
    req_valid = 1'b0;
    check_eq("pre_rst_read", {31'd0, sram_read}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rst_drops_read", {31'd0, sram_read}, 32'd0);
    check_eq("rst_ready", {30'd0, req_ready, busy}, 32'd2);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (rsp_valid) pulses++;
    end
    check_eq("no_rsp_after_abort", pulses, 32'd0);
    check_eq("ready_after_abort", {31'd0, req_ready}, 32'd1);

    // Randomized mix over a small address pool including both address extremes.
    pool[0] = 16'h0000; pool[1] = 16'hFFFF;
    for (int i = 2; i < 8; i++) pool[i] = 16'($urandom);
    for (int i = 0; i < 60; i++) begin
      int r;
      logic [15:0] a;
      bit h;
      r = $urandom_range(0, 9);
      a = pool[$urandom_range(0, 7)];
      h = 1'($urandom_range(0, 1));
      if (r < 4) begin
        do_access(1'b1, a, 8'($urandom), h);
      end else if (r < 8) begin
        do_access(1'b0, a, 8'($urandom), h);
      end else begin
        do_dump(1'($urandom_range(0, 1)));
      end
      req_valid = 1'b0;
    end

    // Longer hold-time build: write 0xFFFF <- 0xA5 and read it back.
    b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 16'hFFFF; b_req_wdata = 8'hA5;
    step();
    b_req_valid = 1'b0;
    width = 0;
    for (int k = 0; k < 10; k++) begin
      if (b_sram_write) begin
        width++;
        check_eq("b_wr_addr_data", {b_sram_addr, 8'd0, b_sram_wdata}, 32'hFFFF_00A5);
      end
      step();
    end
    check_eq("b_write_width", width, WC_B);
    check_eq("b_ready_after_wr", {31'd0, b_req_ready}, 32'd1);
    b_req_valid = 1'b1; b_req_write = 1'b0;
    step();
    b_req_valid = 1'b0;
    width = 0; pulses = 0; pulse_at = 0; got_rd = 8'h00;
    for (int k = 1; k <= 10; k++) begin
      if (b_sram_read) width++;
      if (b_rsp_valid) begin
        pulses++;
        pulse_at = k;
        got_rd = b_rsp_rdata;
      end
      step();
    end
    check_eq("b_read_width", width, RC_B);
    check_eq("b_rsp_pulses", pulses, 32'd1);
    check_eq("b_rsp_cycle", pulse_at, RC_B + 1);
    check_eq("b_rsp_data", {24'd0, got_rd}, 32'h0000_00A5);

    check_eq("rd_wr_overlap", overlap, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
